// File: rtl/modacc.sv
// Frame-based modular accumulator: sums LEN residues per frame modulo MOD and holds
// the result under a valid/ready handshake until the consumer takes it.
module modacc #(
    parameter int unsigned       MWIDTH = 39,
    parameter int unsigned       LWIDTH = 10,
    parameter logic [MWIDTH-1:0] MOD    = 39'h40_0080_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_acc_flush,
    input  logic              i_acc_vld,
    output logic              o_acc_rdy,
    input  logic [MWIDTH-1:0] i_acc_din,
    input  logic [LWIDTH-1:0] i_acc_len,
    output logic              o_acc_vldout,
    input  logic              i_acc_out_rdy,
    output logic [MWIDTH-1:0] o_acc_dout
);

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    localparam logic [LWIDTH-1:0] LenOne = LWIDTH'(1);

    state_e            state_q, state_d;
    logic [LWIDTH-1:0] cnt_q, cnt_d;
    logic [LWIDTH-1:0] len_q, len_d;
    logic [MWIDTH-1:0] acc_q, acc_d;
    logic [MWIDTH-1:0] dout_q, dout_d;

    logic              accept;
    logic              frame_end;
    logic [LWIDTH-1:0] len_eff;
    logic [MWIDTH:0]   sum;
    logic [MWIDTH-1:0] diff;
    logic [MWIDTH-1:0] add_res;

    assign o_acc_rdy    = (state_q != StHold);
    assign o_acc_vldout = (state_q == StHold);
    assign o_acc_dout   = dout_q;
    assign accept       = i_acc_vld && o_acc_rdy;

    // The first word of a frame carries the length; later words use the latched copy.
    assign len_eff   = (state_q == StIdle) ? i_acc_len : len_q;
    assign frame_end = (cnt_q == len_eff - LenOne);

    // diff wraps modulo 2^MWIDTH, which is exact whenever sum >= MOD.
    assign sum     = {1'b0, acc_q} + {1'b0, i_acc_din};
    assign diff    = acc_q + i_acc_din - MOD;
    assign add_res = (sum >= {1'b0, MOD}) ? diff : sum[MWIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        if (i_acc_flush) begin
            state_d = StIdle;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        len_d = i_acc_len;
                        acc_d = i_acc_din;
                        cnt_d = LenOne;
                        if (frame_end) begin
                            dout_d  = i_acc_din;
                            state_d = StHold;
                        end else begin
                            state_d = StAcc;
                        end
                    end
                end
                StAcc: begin
                    if (accept) begin
                        acc_d = add_res;
                        cnt_d = cnt_q + LenOne;
                        if (frame_end) begin
                            dout_d  = add_res;
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (i_acc_out_rdy) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_modacc.sv
// Scoreboard bench for modacc: a default-width instance plus an LWIDTH=2 instance for
// the length-0 wrap case.
module tb_modacc;

    localparam int MW = 39;
    localparam int LW = 10;
    localparam longint unsigned MODL = 64'h40_0080_0001;
    localparam logic [MW-1:0] MODV = 39'h40_0080_0001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0, vld = 1'b0, out_rdy = 1'b1;
    logic          rdy, vldout;
    logic [MW-1:0] din = '0, dout;
    logic [LW-1:0] len = '0;

    logic          w_flush = 1'b0, w_vld = 1'b0, w_out_rdy = 1'b1;
    logic          w_rdy, w_vldout;
    logic [MW-1:0] w_din = '0, w_dout;
    logic [1:0]    w_len = '0;

    int total = 0;
    int bad   = 0;
    logic [MW-1:0] exp_q[$];
    logic [MW-1:0] exp_w[$];
    logic [MW-1:0] mon_e, mon_we;

    always #5 clk = ~clk;

    modacc dut (
        .clk(clk), .rst(rst), .i_acc_flush(flush), .i_acc_vld(vld), .o_acc_rdy(rdy),
        .i_acc_din(din), .i_acc_len(len), .o_acc_vldout(vldout),
        .i_acc_out_rdy(out_rdy), .o_acc_dout(dout)
    );

    modacc #(.LWIDTH(2)) dut_w (
        .clk(clk), .rst(rst), .i_acc_flush(w_flush), .i_acc_vld(w_vld), .o_acc_rdy(w_rdy),
        .i_acc_din(w_din), .i_acc_len(w_len), .o_acc_vldout(w_vldout),
        .i_acc_out_rdy(w_out_rdy), .o_acc_dout(w_dout)
    );

    function automatic logic [MW-1:0] madd(input logic [MW-1:0] a, input logic [MW-1:0] b);
        longint unsigned s;
        s = (longint'(a) + longint'(b)) % MODL;
        return s[MW-1:0];
    endfunction

    // Result handshakes are observed on the falling edge, ahead of the accepting edge.
    always @(negedge clk) begin
        if (!rst && !flush && vldout && out_rdy) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL result: got dout=%0h, no result expected", dout);
            end else begin
                mon_e = exp_q.pop_front();
                if (dout !== mon_e) begin
                    bad++;
                    $display("FAIL result: got dout=%0h, want %0h", dout, mon_e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && !w_flush && w_vldout && w_out_rdy) begin
            total++;
            if (exp_w.size() == 0) begin
                bad++;
                $display("FAIL w_result: got dout=%0h, no result expected", w_dout);
            end else begin
                mon_we = exp_w.pop_front();
                if (w_dout !== mon_we) begin
                    bad++;
                    $display("FAIL w_result: got dout=%0h, want %0h", w_dout, mon_we);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [MW-1:0] d, input logic [LW-1:0] l);
        int n = 0;
        vld = 1'b1; din = d; len = l;
        while (!rdy && n < 50) begin
            step(1);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout: rdy=%0b after %0d cycles, want 1", rdy, n);
        end
        step(1);
        vld = 1'b0;
    endtask

    task automatic wsend(input logic [MW-1:0] d, input logic [1:0] l);
        int n = 0;
        w_vld = 1'b1; w_din = d; w_len = l;
        while (!w_rdy && n < 50) begin
            step(1);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL wsend_timeout: rdy=%0b after %0d cycles, want 1", w_rdy, n);
        end
        step(1);
        w_vld = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        total += 4;
        if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %0b want 1", rdy); end
        if (vldout !== 1'b0) begin bad++; $display("FAIL reset_vld: got %0b want 0", vldout); end
        if (dout !== '0) begin bad++; $display("FAIL reset_dout: got %0h want 0", dout); end
        if (w_rdy !== 1'b1) begin bad++; $display("FAIL reset_w_rdy: got %0b want 1", w_rdy); end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_back_to_back;
        exp_q.push_back(madd(madd(MODV - 1, MODV - 1), 39'd2));
        send(MODV - 1, 10'd3);
        send(MODV - 1, 10'd3);
        total++;
        if (vldout !== 1'b0) begin bad++; $display("FAIL b2b_early: vld=%0b want 0", vldout); end
        send(39'd2, 10'd3);
        total++;
        if (vldout !== 1'b1) begin bad++; $display("FAIL b2b_latency: vld=%0b want 1", vldout); end
        step(2);
    endtask

    task automatic test_hold;
        out_rdy = 1'b0;
        exp_q.push_back(39'd5);
        send(39'd5, 10'd1);
        for (int i = 0; i < 4; i++) begin
            total += 3;
            if (rdy !== 1'b0) begin bad++; $display("FAIL hold_rdy: got %0b want 0", rdy); end
            if (vldout !== 1'b1) begin bad++; $display("FAIL hold_vld: got %0b want 1", vldout); end
            if (dout !== 39'd5) begin bad++; $display("FAIL hold_dout: got %0h want 5", dout); end
            step(1);
        end
        out_rdy = 1'b1;
        step(1);
        total += 3;
        if (vldout !== 1'b0) begin bad++; $display("FAIL hold_release: vld=%0b want 0", vldout); end
        if (rdy !== 1'b1) begin bad++; $display("FAIL hold_rdy_back: got %0b want 1", rdy); end
        if (dout !== 39'd5) begin bad++; $display("FAIL hold_keep: got %0h want 5", dout); end
    endtask

    task automatic test_bubbles;
        exp_q.push_back(39'd10);
        for (int i = 1; i <= 4; i++) begin
            send(MW'(i), 10'd4);
            step(i);
        end
        // Same frame without bubbles; later len values must be ignored.
        exp_q.push_back(39'd10);
        send(39'd1, 10'd4);
        send(39'd2, 10'd9);
        send(39'd3, 10'd1);
        send(39'd4, 10'd0);
        step(2);
    endtask

    task automatic test_flush;
        send(39'd100, 10'd4);
        send(39'd200, 10'd4);
        flush = 1'b1; vld = 1'b1; din = 39'd99; len = 10'd1;
        step(1);
        flush = 1'b0; vld = 1'b0;
        total += 2;
        if (rdy !== 1'b1) begin bad++; $display("FAIL flush_rdy: got %0b want 1", rdy); end
        if (vldout !== 1'b0) begin bad++; $display("FAIL flush_vld: got %0b want 0", vldout); end
        exp_q.push_back(39'd15);
        send(39'd7, 10'd2);
        send(39'd8, 10'd2);
        step(2);
        // A held result is dropped by flush but dout keeps its value.
        out_rdy = 1'b0;
        send(39'd9, 10'd1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        total += 2;
        if (vldout !== 1'b0) begin bad++; $display("FAIL flush_hold_vld: got %0b want 0", vldout); end
        if (dout !== 39'd9) begin bad++; $display("FAIL flush_hold_dout: got %0h want 9", dout); end
        out_rdy = 1'b1;
        step(2);
    endtask

    task automatic test_len_zero;
        w_out_rdy = 1'b0;
        exp_w.push_back(39'd4);
        for (int i = 0; i < 3; i++) wsend(39'd1, 2'd0);
        total++;
        if (w_vldout !== 1'b0) begin bad++; $display("FAIL len0_early: vld=%0b want 0", w_vldout); end
        wsend(39'd1, 2'd0);
        total += 2;
        if (w_vldout !== 1'b1) begin bad++; $display("FAIL len0_vld: got %0b want 1", w_vldout); end
        if (w_dout !== 39'd4) begin bad++; $display("FAIL len0_dout: got %0h want 4", w_dout); end
        w_out_rdy = 1'b1;
        step(1);
        total++;
        if (w_rdy !== 1'b1) begin bad++; $display("FAIL len0_rdy: got %0b want 1", w_rdy); end
        exp_w.push_back(39'd11);
        wsend(39'd5, 2'd2);
        wsend(39'd6, 2'd2);
        step(2);
    endtask

    task automatic test_rst_mid;
        send(39'd100, 10'd3);
        send(39'd200, 10'd3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        total += 3;
        if (vldout !== 1'b0) begin bad++; $display("FAIL rst_mid_vld: got %0b want 0", vldout); end
        if (dout !== '0) begin bad++; $display("FAIL rst_mid_dout: got %0h want 0", dout); end
        if (rdy !== 1'b1) begin bad++; $display("FAIL rst_mid_rdy: got %0b want 1", rdy); end
        exp_q.push_back(39'd42);
        send(39'd20, 10'd2);
        send(39'd22, 10'd2);
        step(2);
        out_rdy = 1'b0;
        send(39'd77, 10'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        total += 3;
        if (vldout !== 1'b0) begin bad++; $display("FAIL rst_hold_vld: got %0b want 0", vldout); end
        if (dout !== '0) begin bad++; $display("FAIL rst_hold_dout: got %0h want 0", dout); end
        if (rdy !== 1'b1) begin bad++; $display("FAIL rst_hold_rdy: got %0b want 1", rdy); end
        out_rdy = 1'b1;
        exp_q.push_back(madd(madd(MODV - 5, 39'd3), 39'd4));
        send(MODV - 5, 10'd3);
        send(39'd3, 10'd3);
        send(39'd4, 10'd3);
        step(2);
    endtask

    task automatic test_drain;
        int n = 0;
        while ((exp_q.size() != 0 || exp_w.size() != 0) && n < 20) begin
            step(1);
            n++;
        end
        total += 2;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL drain: %0d results missing, want 0", exp_q.size());
        end
        if (exp_w.size() != 0) begin
            bad++; $display("FAIL w_drain: %0d results missing, want 0", exp_w.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_hold();
        test_bubbles();
        test_flush();
        test_len_zero();
        test_rst_mid();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
